// File: rtl/irq_enc_pkg.sv
// Shared constants and helpers for the 8-to-3 interrupt priority encoder.
// The one-hot mapping matches the 3x8 decoder: code c drives line c, line 0 is code 3'b000.
package irq_enc_pkg;

    localparam int N_IN   = 8;
    localparam int CODE_W = 3;

    function automatic logic [0:N_IN-1] onehot3to8(input logic [CODE_W-1:0] c);
        logic [0:N_IN-1] r;
        r    = '0;
        r[c] = 1'b1;
        return r;
    endfunction

    function automatic logic [CODE_W:0] popcount8(input logic [0:N_IN-1] v);
        logic [CODE_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < N_IN; i++) begin
            cnt = cnt + {{CODE_W{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/irq_priority_encoder_prio_enc8.sv
// Combinational lowest-index-wins encoder over an 8-line vector.
// The index reads 0 when no line is set, so qualify it with any_o.
module prio_enc8
    import irq_enc_pkg::*;
(
    input  logic [0:N_IN-1]   vec_i,
    output logic [CODE_W-1:0] idx_o,
    output logic              any_o,
    output logic              multi_o
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        idx_o = '0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = CODE_W'(i);
            end
        end
    end

    assign any_o   = |vec_i;
    assign multi_o = (popcount8(vec_i) > (CODE_W + 1)'(1));

endmodule

// File: rtl/irq_priority_encoder.sv
// Registered 8-to-3 priority encoder with sticky request capture and a valid/ready output.
// A presented code is frozen until the consumer accepts it.
module irq_priority_encoder
    import irq_enc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [0:N_IN-1]   req,
    input  logic [0:N_IN-1]   mask,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    input  logic              ready,
    output logic              multi,
    output logic [0:N_IN-1]   pending
);

    logic [0:N_IN-1]   pending_q, pending_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              valid_q, valid_d;
    logic              multi_q, multi_d;

    logic              accept;
    logic              load;
    logic [0:N_IN-1]   clr;
    logic [0:N_IN-1]   sel_d;
    logic [CODE_W-1:0] win_idx;
    logic              win_any;
    logic              win_multi;

    assign accept = valid_q & ready;
    assign load   = ~valid_q | accept;

    // New requests are OR-ed in after the clear, so a re-request on the accepting edge survives.
    always_comb begin
        clr       = accept ? onehot3to8(code_q) : '0;
        pending_d = (pending_q & ~clr) | req;
        sel_d     = pending_d & ~mask;
    end

    prio_enc8 u_prio_enc8 (
        .vec_i   (sel_d),
        .idx_o   (win_idx),
        .any_o   (win_any),
        .multi_o (win_multi)
    );

    always_comb begin
        valid_d = valid_q;
        code_d  = code_q;
        multi_d = multi_q;
        if (load) begin
            valid_d = win_any;
            code_d  = win_idx;
            multi_d = win_multi;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            valid_q   <= 1'b0;
            code_q    <= '0;
            multi_q   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
            multi_q   <= multi_d;
        end
    end

    assign code    = code_q;
    assign valid   = valid_q;
    assign multi   = multi_q;
    assign pending = pending_q;

endmodule
